img_mem_reader: RTL and testbench

Frame source on the memory-controller side of the Sobel datapath. On a start command it reads one grayscale frame (IMG_W x IMG_H bytes, raster order) from a synchronous single-port image BRAM and streams it as a byte/enable pair into the filter's DATA/DATA_EN input. It also drives the filter's run level and collects its done signal, then reports frame completion upstream. It is the producer end of the filter's data interface.

---
 rtl/img_mem_reader.sv | 116 +++++++++++
 tb/tb_img_mem_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_mem_reader.sv
// Frame source for the Sobel filter: reads one raster-order frame from a synchronous BRAM,
// streams it as DATA/DATA_EN, runs the core and reports completion upstream.
module img_mem_reader #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START_I,
  input  logic [ADDR_W-1:0] BASE_ADDR_I,
  input  logic              PAUSE_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic [ADDR_W-1:0] MEM_ADDR_O,
  output logic              MEM_RD_O,
  input  logic [7:0]        MEM_DATA_I,
  output logic [7:0]        DATA_O,
  output logic              DATA_EN_O,
  output logic              CORE_RUN_O,
  input  logic              CORE_DONE_I
);

  localparam int unsigned NPix  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(NPix + 1);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StWaitCore, StDone} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic              rd_v1_q;
  logic              done_flag_q;
  logic              busy_q, done_q, mem_rd_q, data_en_q, run_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        data_q;

  logic [ADDR_W-1:0] rd_addr;
  logic              last_rd;
  logic              pipe_empty;

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign rd_addr    = base_q + ADDR_W'(cnt_q);
  assign last_rd    = (cnt_q == CNT_W'(NPix - 1));
  assign pipe_empty = !mem_rd_q && !rd_v1_q && !data_en_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      base_q      <= '0;
      rd_v1_q     <= 1'b0;
      done_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      data_en_q   <= 1'b0;
      data_q      <= '0;
      run_q       <= 1'b0;
    end else begin
      // Read pipeline runs independently of the FSM so issued reads always land.
      rd_v1_q   <= mem_rd_q;
      data_en_q <= rd_v1_q;
      if (rd_v1_q) data_q <= MEM_DATA_I;
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      if (state_q != StIdle) done_flag_q <= done_flag_q | CORE_DONE_I;

      case (state_q)
        StIdle: begin
          if (START_I) begin
            base_q      <= BASE_ADDR_I;
            cnt_q       <= '0;
            done_flag_q <= 1'b0;
            run_q       <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StRead;
          end
        end
        StRead: begin
          if (!PAUSE_I) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= rd_addr;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (last_rd) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pipe_empty) state_q <= StWaitCore;
        end
        StWaitCore: begin
          if (done_flag_q || CORE_DONE_I) begin
            run_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign BUSY_O     = busy_q;
  assign DONE_O     = done_q;
  assign MEM_ADDR_O = mem_addr_q;
  assign MEM_RD_O   = mem_rd_q;
  assign DATA_O     = data_q;
  assign DATA_EN_O  = data_en_q;
  assign CORE_RUN_O = run_q;

endmodule

// File: tb/tb_img_mem_reader.sv
// Bench for img_mem_reader on a 4x2 frame: table-driven frames, random frames and a mid-frame
// reset, all checked against a list-level model of the expected read/stream sequence.
module tb_img_mem_reader;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 2;
  localparam int unsigned ADDR_W = 16;
  localparam int          N      = 8;
  localparam int          HistSz = 8192;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START_I = 1'b0;
  logic [15:0] BASE_ADDR_I = '0;
  logic        PAUSE_I = 1'b0;
  logic        BUSY_O, DONE_O, MEM_RD_O, DATA_EN_O, CORE_RUN_O;
  logic [15:0] MEM_ADDR_O;
  logic [7:0]  MEM_DATA_I = '0;
  logic [7:0]  DATA_O;
  logic        CORE_DONE_I = 1'b0;

  img_mem_reader #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START_I    (START_I),
    .BASE_ADDR_I(BASE_ADDR_I),
    .PAUSE_I    (PAUSE_I),
    .BUSY_O     (BUSY_O),
    .DONE_O     (DONE_O),
    .MEM_ADDR_O (MEM_ADDR_O),
    .MEM_RD_O   (MEM_RD_O),
    .MEM_DATA_I (MEM_DATA_I),
    .DATA_O     (DATA_O),
    .DATA_EN_O  (DATA_EN_O),
    .CORE_RUN_O (CORE_RUN_O),
    .CORE_DONE_I(CORE_DONE_I)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Image BRAM: byte at address a is a[7:0] ^ key, one-cycle read latency.
  logic [7:0] key = '0;
  function automatic logic [7:0] px(input logic [15:0] a);
    return a[7:0] ^ key;
  endfunction
  always @(posedge CLK) if (MEM_RD_O) MEM_DATA_I <= px(MEM_ADDR_O);

  // Observed transactions, stamped with the cycle they were seen in.
  logic [15:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [7:0]  en_data_q[$];
  int          en_cyc_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  bit          busy_h[HistSz];
  bit          run_h[HistSz];
  bit          pause_h[HistSz];

  always @(negedge CLK) begin
    if (MEM_RD_O) begin
      rd_addr_q.push_back(MEM_ADDR_O);
      rd_cyc_q.push_back(cyc);
    end
    if (DATA_EN_O) begin
      en_data_q.push_back(DATA_O);
      en_cyc_q.push_back(cyc);
    end
    if (DONE_O) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    busy_h[cyc % HistSz]  = BUSY_O;
    run_h[cyc % HistSz]   = CORE_RUN_O;
    pause_h[cyc % HistSz] = PAUSE_I;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    en_data_q.delete();
    en_cyc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // done_mode 0: CORE_DONE pulsed done_at cycles after the last enable.
  // done_mode 1: CORE_DONE pulsed once done_at reads have been issued.
  typedef struct {
    logic [15:0] base;
    int          pause_after;
    int          pause_len;
    bit          rand_pause;
    int          done_mode;
    int          done_at;
    int          start_mid_at;
    logic [7:0]  key;
    int          exp_gap;
  } frame_t;

  // Must be called just after a rising edge with the DUT idle.
  task automatic run_frame(input frame_t f);
    int s, issued, ens, last_en, pause_left, pulse_c, exp_gap;
    bit paused_once, done_sent, mid_sent, ok_b, ok_r;
    logic [15:0] ea;
    issued = 0; ens = 0; last_en = -1; pause_left = 0; pulse_c = -1;
    paused_once = 0; done_sent = 0; mid_sent = 0;
    key = f.key;
    clear_obs();
    START_I = 1'b1;
    BASE_ADDR_I = f.base;
    s = cyc;
    for (int b = 0; b < 300; b++) begin
      @(posedge CLK); #1;
      START_I = 1'b0;
      CORE_DONE_I = 1'b0;
      if (done_cnt > 0) break;
      if (MEM_RD_O) issued++;
      if (DATA_EN_O) begin
        ens++;
        last_en = cyc;
      end
      if (f.rand_pause) PAUSE_I = ($urandom_range(0, 3) == 0);
      else begin
        if (!paused_once && issued == f.pause_after) begin
          paused_once = 1;
          pause_left = f.pause_len;
        end
        PAUSE_I = (pause_left > 0);
        if (pause_left > 0) pause_left--;
      end
      if (!mid_sent && issued == f.start_mid_at) begin
        mid_sent = 1;
        START_I = 1'b1;
        BASE_ADDR_I = 16'h0400;
      end
      if (!done_sent) begin
        if ((f.done_mode == 1 && issued == f.done_at) ||
            (f.done_mode == 0 && ens == N && cyc == last_en + f.done_at)) begin
          CORE_DONE_I = 1'b1;
          done_sent = 1;
          pulse_c = cyc;
        end
      end
    end
    PAUSE_I = 1'b0;
    START_I = 1'b0;
    CORE_DONE_I = 1'b0;
    if (done_cnt == 0) begin
      check("frame_timeout", 32'(done_cnt), 32'd1);
      return;
    end
    check("busy_after_done", 32'(BUSY_O), 32'd0);
    check("rd_count", 32'(rd_addr_q.size()), 32'(N));
    check("en_count", 32'(en_data_q.size()), 32'(N));
    for (int k = 0; k < N; k++) begin
      ea = f.base + 16'(k);
      if (k < rd_addr_q.size()) check("rd_addr", 32'(rd_addr_q[k]), 32'(ea));
      if (k < en_data_q.size()) check("data", 32'(en_data_q[k]), 32'(px(ea)));
      if (k < en_cyc_q.size() && k < rd_cyc_q.size())
        check("en_latency", 32'(en_cyc_q[k] - rd_cyc_q[k]), 32'd2);
    end
    if (rd_cyc_q.size() == N) begin
      exp_gap = f.exp_gap;
      if (f.rand_pause) begin
        exp_gap = 0;
        for (int c = rd_cyc_q[0]; c < rd_cyc_q[N-1]; c++) if (pause_h[c % HistSz]) exp_gap++;
      end
      check("rd_span", 32'(rd_cyc_q[N-1] - rd_cyc_q[0]), 32'(N - 1 + exp_gap));
    end
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (f.done_mode == 0) check("done_timing", 32'(done_cyc), 32'(pulse_c + 1));
    else check("done_after_drain", 32'((done_cyc > last_en) && (done_cyc <= last_en + 4)), 32'd1);
    ok_b = 1;
    ok_r = 1;
    for (int c = s + 1; c <= done_cyc; c++) begin
      if (!busy_h[c % HistSz]) ok_b = 0;
      if (run_h[c % HistSz] != (c < done_cyc)) ok_r = 0;
    end
    check("busy_window", 32'(ok_b), 32'd1);
    check("run_window", 32'(ok_r), 32'd1);
  endtask

  frame_t vecs[4];
  frame_t rf;
  int     issued;

  initial begin
    vecs[0] = '{16'h0010, -1, 0, 1'b0, 0, 5, -1, 8'h00, 0};  // plain frame
    vecs[1] = '{16'h0010,  3, 3, 1'b0, 0, 5, -1, 8'h00, 3};  // 3-cycle stall after 3rd read
    vecs[2] = '{16'hFFFE, -1, 0, 1'b0, 0, 5, -1, 8'h00, 0};  // address wrap
    vecs[3] = '{16'h0010, -1, 0, 1'b0, 1, 3,  5, 8'h00, 0};  // early done, ignored START

    #2;
    check("reset_outputs",
          32'({BUSY_O, DONE_O, MEM_RD_O, DATA_EN_O, CORE_RUN_O, MEM_ADDR_O, DATA_O}), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    check("idle_busy", 32'(BUSY_O), 32'd0);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Reset in the middle of a frame, then a clean rerun.
    key = 8'h00;
    clear_obs();
    START_I = 1'b1;
    BASE_ADDR_I = 16'h0010;
    issued = 0;
    for (int b = 0; b < 50 && issued < 4; b++) begin
      @(posedge CLK); #1;
      START_I = 1'b0;
      if (MEM_RD_O) issued++;
    end
    check("reads_before_reset", 32'(issued), 32'd4);
    RST_N = 1'b0;
    #1;
    check("midreset_outputs",
          32'({BUSY_O, DONE_O, MEM_RD_O, DATA_EN_O, CORE_RUN_O, MEM_ADDR_O, DATA_O}), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    clear_obs();
    repeat (6) @(posedge CLK);
    #1;
    check("no_reads_after_reset", 32'(rd_addr_q.size()), 32'd0);
    check("no_data_after_reset", 32'(en_data_q.size()), 32'd0);
    check("idle_after_reset", 32'(BUSY_O), 32'd0);
    run_frame(vecs[0]);

    for (int i = 0; i < 16; i++) begin
      rf.base         = 16'($urandom);
      rf.pause_after  = -1;
      rf.pause_len    = 0;
      rf.rand_pause   = 1'b1;
      rf.done_mode    = int'($urandom_range(0, 1));
      rf.done_at      = (rf.done_mode == 1) ? int'($urandom_range(1, N)) :
                                              int'($urandom_range(5, 9));
      rf.start_mid_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N - 1)) : -1;
      rf.key          = 8'($urandom);
      rf.exp_gap      = 0;
      run_frame(rf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
